// File: rtl/burst_pulse_gen.sv
// burst_pulse_gen: emits a burst of PULSES high/low pulses on each rising edge of start
module burst_pulse_gen #(
  parameter int PULSES   = 4,
  parameter int HIGH_CYC = 3,
  parameter int LOW_CYC  = 2,
  parameter int CW       = 4,
  parameter int IW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          pulse_out,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] pulse_idx
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t        state;
  logic          start_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          rise, high_end, low_end, last;
  assign rise     = start & ~start_q;
  assign high_end = cnt == CW'(HIGH_CYC - 1);
  assign low_end  = cnt == CW'(LOW_CYC - 1);
  assign last     = idx == IW'(PULSES - 1);
  // Burst sequencer; start is only looked at in IDLE (edge) and DONE (level)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: if (rise) begin
          state <= HIGH;
          cnt   <= '0;
          idx   <= '0;
        end
        HIGH: if (high_end) begin
          state <= last ? DONE : LOW;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        LOW: if (low_end) begin
          state <= HIGH;
          cnt   <= '0;
          idx   <= idx + 1'b1;
        end else cnt <= cnt + 1'b1;
        DONE: if (!start) begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  assign pulse_out = state == HIGH;
  assign busy      = (state == HIGH) || (state == LOW);
  assign done      = state == DONE;
  assign pulse_idx = idx;
endmodule

// File: tb/tb_burst_pulse_gen.sv
// tb_burst_pulse_gen: table-driven scoreboard bench for burst_pulse_gen
module tb_burst_pulse_gen;
  typedef struct {
    bit         sel;
    bit         rst;
    bit         start;
    logic [5:0] exp;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic       p1, b1, d1, p2, b2, d2;
  logic [2:0] i1, i2;
  vec_t       vecs[$];
  vec_t       exp_q[$];
  int         checks = 0, failures = 0, vnum = 0;
  bit         prev_rst = 1'b1;

  burst_pulse_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .pulse_out(p1), .busy(b1), .done(d1), .pulse_idx(i1)
  );

  burst_pulse_gen #(.PULSES(1), .HIGH_CYC(1), .LOW_CYC(1), .CW(1), .IW(3)) dut_min (
    .clk(clk), .rst(rst), .start(start2),
    .pulse_out(p2), .busy(b2), .done(d2), .pulse_idx(i2)
  );

  always #5 clk = ~clk;

  function automatic void add(bit sel, bit r, bit s, bit p, bit b, bit d, int i);
    vec_t v;
    v.sel = sel; v.rst = r; v.start = s;
    v.exp = {p, b, d, 3'(i)};
    vecs.push_back(v);
  endfunction

  // burst position k of the default burst: pattern 111 00 repeating, index = k/5
  function automatic void add_pos(bit s, int k);
    add(1'b0, 1'b0, s, (k % 5) < 3, 1'b1, 1'b0, k / 5);
  endfunction

  // Monitor: pop expected record after each edge and compare against the selected DUT
  initial forever begin
    vec_t e;
    logic [5:0] got;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = e.sel ? {p2, b2, d2, i2} : {p1, b1, d1, i1};
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL vec%0d dut%0d pulse/busy/done/idx got=%b required=%b",
                 vnum, e.sel, got, e.exp);
      end
      vnum++;
    end
  end

  initial begin
    // 1: reset held while start toggles
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, k % 2 == 0, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 2: rise then start held high, then dropped
    for (int k = 0; k < 18; k++) add_pos(1'b1, k);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 3: single-cycle start pulse, done lasts one cycle
    add_pos(1'b1, 0);
    for (int k = 1; k < 18; k++) add_pos(1'b0, k);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 4: start toggling during the burst and into done
    for (int k = 0; k < 18; k++) add_pos(k % 2 == 0, k);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 5: reset in the 2nd pulse with start high; restart on release
    for (int k = 0; k < 6; k++) add_pos(1'b1, k);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 18; k++) add_pos(1'b1, k);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 6: minimal configuration, one 1-cycle pulse
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst;
      if (vecs[n].sel) start2 = vecs[n].start;
      else start = vecs[n].start;
      exp_q.push_back(vecs[n]);
      // reset assertion must clear outputs before any clock edge
      if (vecs[n].rst && !prev_rst) begin
        #1;
        checks++;
        if ({p1, b1, d1, i1} !== 6'b0) begin
          failures++;
          $display("FAIL async_rst pulse/busy/done/idx got=%b required=%b",
                   {p1, b1, d1, i1}, 6'b0);
        end
      end
      prev_rst = vecs[n].rst;
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
